// File: rtl/des_multi_pkg.sv
// des_multi_pkg: shared definitions for the DES multi-engine controller.
// Holds the CPU opcodes, the command-FSM and per-core FSM state encodings,
// and the helper that sizes core-index fields.
package des_multi_pkg;

    localparam logic [3:0] OP_SET_REGION = 4'd0;
    localparam logic [3:0] OP_START      = 4'd1;
    localparam logic [3:0] OP_START_ALL  = 4'd2;
    localparam logic [3:0] OP_RESTART    = 4'd3;

    typedef enum logic {
        CMD_IDLE = 1'b0,
        CMD_ACK  = 1'b1
    } cmd_state_t;

    typedef enum logic [1:0] {
        CORE_IDLE    = 2'd0,
        CORE_RUNNING = 2'd1,
        CORE_PENDING = 2'd2
    } core_state_t;

    // Width of a core index; never below one bit so single-core builds still
    // have a legal result_core port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/des_multi_core_ctrl_if.sv
// des_multi_core_ctrl_if: CPU-side bundle of the DES multi-engine controller.
//   cmd/cmd_valid/region/cmd_read : four-phase command handshake
//   cmd_err, busy                 : status
//   result_*                      : arbitrated result port
//   cmd_state_dbg, core_state_dbg : FSM state taps (2 bits per core)
//
// Handshakes: the command side is four-phase -- the CPU holds cmd_valid (and
// cmd/region) until it sees cmd_read, then drops cmd_valid; cmd_read drops the
// cycle after cmd_valid is sampled low. The result side is valid/ready -- a
// result transfers on a clock edge where result_valid and result_ready are
// both 1; while result_valid=1 and result_ready=0 the slot holds stable.
interface des_multi_core_ctrl_if #(
    parameter int NUM_CORES = 4
);
    import des_multi_pkg::*;

    localparam int IDX_W = idx_width(NUM_CORES);

    logic [31:0]            cmd;
    logic                   cmd_valid;
    logic [31:0]            region;
    logic                   cmd_read;
    logic                   cmd_err;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ready;
    logic [IDX_W-1:0]       result_core;
    logic [63:0]            result_counter;
    logic [63:0]            result_ciphertext;
    cmd_state_t             cmd_state_dbg;
    logic [2*NUM_CORES-1:0] core_state_dbg;

    modport master (
        output cmd, cmd_valid, region, result_ready,
        input  cmd_read, cmd_err, busy, result_valid, result_core,
               result_counter, result_ciphertext, cmd_state_dbg, core_state_dbg
    );

    modport slave (
        input  cmd, cmd_valid, region, result_ready,
        output cmd_read, cmd_err, busy, result_valid, result_core,
               result_counter, result_ciphertext, cmd_state_dbg, core_state_dbg
    );

endinterface

// File: rtl/des_rr_arbiter.sv
// des_rr_arbiter: round-robin arbiter over NUM_CORES requests.
//   req       in  pending-result request vector
//   en        in  a grant may be issued this cycle
//   grant     out one-hot grant (zero when disabled or nothing requests)
//   grant_idx out index of the granted requester
// The search starts one past the last granted index; after reset the last
// grant is NUM_CORES-1 so core 0 has first priority.
module des_rr_arbiter
    import des_multi_pkg::*;
#(
    parameter int NUM_CORES = 4,
    localparam int IDX_W = idx_width(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 en,
    output logic [NUM_CORES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] j;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = last_q;
        found     = 1'b0;
        j         = '0;
        if (en) begin
            for (int k = 1; k <= NUM_CORES; k++) begin
                j = IDX_W'((int'(last_q) + k) % NUM_CORES);
                if (!found && req[j]) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = j;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= IDX_W'(NUM_CORES - 1);
        end else if (|grant) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/des_multi_core_ctrl.sv
// des_multi_core_ctrl: command decoder, per-engine FSMs, result capture and
// round-robin result slot for an array of DES key-search engines.
//   clk, rst        : clock, synchronous active-high reset
//   cpu             : CPU command/result bundle (slave side)
//   core_start      : one-cycle start pulse per engine
//   core_restart    : one-cycle restart pulse per engine
//   core_region     : per-engine region register, engine i at slice i
//   core_done       : engine finished (level or pulse, seen only while RUNNING)
//   core_counter    : per-engine counter, CNT_W bits each
//   core_ciphertext : per-engine ciphertext, 64 bits each
module des_multi_core_ctrl
    import des_multi_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int REGION_W  = 16,
    parameter int CNT_W     = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    des_multi_core_ctrl_if.slave          cpu,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES-1:0]          core_restart,
    output logic [NUM_CORES*REGION_W-1:0] core_region,
    input  logic [NUM_CORES-1:0]          core_done,
    input  logic [NUM_CORES*CNT_W-1:0]    core_counter,
    input  logic [NUM_CORES*64-1:0]       core_ciphertext
);

    localparam int IDX_W = idx_width(NUM_CORES);

    cmd_state_t           cmd_state, cmd_state_nxt;
    core_state_t          core_state     [NUM_CORES];
    core_state_t          core_state_nxt [NUM_CORES];
    logic [3:0]           op, idx;
    logic                 idx_ok, cmd_fire, restart_fire, err_set;
    logic [NUM_CORES-1:0] start_vec, req, grant, capture;
    logic                 arb_en, cmd_err_q, result_valid_q;
    logic [IDX_W-1:0]     grant_idx, result_core_q;
    logic [63:0]          grant_cnt, grant_ct, result_cnt_q, result_ct_q;
    logic [REGION_W-1:0]  region_q [NUM_CORES];
    logic [63:0]          cap_cnt  [NUM_CORES];
    logic [63:0]          cap_ct   [NUM_CORES];
    logic                 unused_bits;

    // Only cmd[11:8], cmd[3:0] and region[REGION_W-1:0] carry meaning.
    assign unused_bits = ^{cpu.cmd, cpu.region};

    // ---------------- command FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) cmd_state <= CMD_IDLE;
        else     cmd_state <= cmd_state_nxt;
    end

    always_comb begin
        cmd_state_nxt = cmd_state;
        case (cmd_state)
            CMD_IDLE: if (cpu.cmd_valid)  cmd_state_nxt = CMD_ACK;
            CMD_ACK:  if (!cpu.cmd_valid) cmd_state_nxt = CMD_IDLE;
            default:  cmd_state_nxt = CMD_IDLE;
        endcase
    end

    // The command acts exactly once, on the IDLE->ACK edge.
    always_comb begin
        cpu.cmd_read = (cmd_state == CMD_ACK);
        cmd_fire     = (cmd_state == CMD_IDLE) && cpu.cmd_valid;
    end

    // ---------------- command decode ----------------
    always_comb begin
        op           = cpu.cmd[3:0];
        idx          = cpu.cmd[11:8];
        idx_ok       = int'(idx) < NUM_CORES;
        start_vec    = '0;
        err_set      = 1'b0;
        restart_fire = 1'b0;
        if (cmd_fire) begin
            case (op)
                OP_SET_REGION: if (!idx_ok) err_set = 1'b1;
                OP_START: begin
                    if (!idx_ok) err_set = 1'b1;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (idx_ok && int'(idx) == i) begin
                            if (core_state[i] == CORE_IDLE) start_vec[i] = 1'b1;
                            else                            err_set      = 1'b1;
                        end
                    end
                end
                OP_START_ALL: begin
                    for (int i = 0; i < NUM_CORES; i++)
                        start_vec[i] = (core_state[i] == CORE_IDLE);
                end
                OP_RESTART: restart_fire = 1'b1;
                default:    err_set = 1'b1;
            endcase
        end
    end

    // ---------------- per-core FSMs ----------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (rst) core_state[i] <= CORE_IDLE;
            else     core_state[i] <= core_state_nxt[i];
        end
    end

    // RESTART overrides every other transition on the same edge.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            core_state_nxt[i] = core_state[i];
            if (restart_fire) begin
                core_state_nxt[i] = CORE_IDLE;
            end else begin
                case (core_state[i])
                    CORE_IDLE:    if (start_vec[i]) core_state_nxt[i] = CORE_RUNNING;
                    CORE_RUNNING: if (core_done[i]) core_state_nxt[i] = CORE_PENDING;
                    CORE_PENDING: if (grant[i])     core_state_nxt[i] = CORE_IDLE;
                    default:                        core_state_nxt[i] = CORE_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i]     = (core_state[i] == CORE_PENDING);
            capture[i] = (core_state[i] == CORE_RUNNING) && core_done[i] && !restart_fire;
            cpu.core_state_dbg[2*i +: 2] = core_state[i];
        end
        cpu.cmd_state_dbg = cmd_state;
        cpu.busy          = result_valid_q || (req != '0);
        for (int i = 0; i < NUM_CORES; i++)
            if (core_state[i] == CORE_RUNNING) cpu.busy = 1'b1;
    end

    // ---------------- capture, regions, pulses, error ----------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (rst) begin
                cap_cnt[i]  <= '0;
                cap_ct[i]   <= '0;
                region_q[i] <= '0;
            end else begin
                if (capture[i]) begin
                    cap_cnt[i] <= 64'(core_counter[i*CNT_W +: CNT_W]);
                    cap_ct[i]  <= core_ciphertext[i*64 +: 64];
                end
                if (cmd_fire && op == OP_SET_REGION && idx_ok && int'(idx) == i)
                    region_q[i] <= cpu.region[REGION_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_start   <= '0;
            core_restart <= '0;
            cmd_err_q    <= 1'b0;
        end else begin
            core_start   <= start_vec;
            core_restart <= {NUM_CORES{restart_fire}};
            cmd_err_q    <= restart_fire ? 1'b0 : (cmd_err_q | err_set);
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_region
        assign core_region[g*REGION_W +: REGION_W] = region_q[g];
    end

    // ---------------- result arbitration and slot ----------------
    // A grant may refill the slot when it is empty or being consumed this
    // edge, which gives one result per cycle without a bubble.
    assign arb_en = !restart_fire && (!result_valid_q || cpu.result_ready);

    des_rr_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        grant_cnt = '0;
        grant_ct  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                grant_cnt = cap_cnt[i];
                grant_ct  = cap_ct[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || restart_fire) begin
            result_valid_q <= 1'b0;
            result_core_q  <= '0;
            result_cnt_q   <= '0;
            result_ct_q    <= '0;
        end else if (grant != '0) begin
            result_valid_q <= 1'b1;
            result_core_q  <= grant_idx;
            result_cnt_q   <= grant_cnt;
            result_ct_q    <= grant_ct;
        end else if (result_valid_q && cpu.result_ready) begin
            result_valid_q <= 1'b0;
        end
    end

    assign cpu.cmd_err           = cmd_err_q;
    assign cpu.result_valid      = result_valid_q;
    assign cpu.result_core       = result_core_q;
    assign cpu.result_counter    = result_cnt_q;
    assign cpu.result_ciphertext = result_ct_q;

endmodule

// File: tb/tb_des_multi_core_ctrl.sv
// tb_des_multi_core_ctrl: directed self-checking bench for des_multi_core_ctrl
// with four engines, 16-bit regions and 48-bit counters.
module tb_des_multi_core_ctrl;

    localparam int NC = 4;
    localparam int RW = 16;
    localparam int CW = 48;

    logic           clk;
    logic           rst;
    logic [NC-1:0]    core_start;
    logic [NC-1:0]    core_restart;
    logic [NC*RW-1:0] core_region;
    logic [NC-1:0]    core_done;
    logic [NC*CW-1:0] core_counter;
    logic [NC*64-1:0] core_ciphertext;

    int checks;
    int failures;

    logic [3:0] st_seen;
    logic [3:0] rs_seen;

    des_multi_core_ctrl_if #(.NUM_CORES(NC)) cpu_if ();

    des_multi_core_ctrl #(.NUM_CORES(NC), .REGION_W(RW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu             (cpu_if),
        .core_start      (core_start),
        .core_restart    (core_restart),
        .core_region     (core_region),
        .core_done       (core_done),
        .core_counter    (core_counter),
        .core_ciphertext (core_ciphertext)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full four-phase command: reports pulses seen in the cycle after
    // cmd_valid rises and checks cmd_read around the handshake.
    task automatic issue(input logic [31:0] c, input logic [31:0] r,
                         output logic [3:0] st, output logic [3:0] rs);
        cpu_if.cmd       = c;
        cpu_if.region    = r;
        cpu_if.cmd_valid = 1'b1;
        step();
        st = core_start;
        rs = core_restart;
        check("cmd_read_high", 64'(cpu_if.cmd_read), 64'd1);
        cpu_if.cmd_valid = 1'b0;
        step();
        check("cmd_read_low", 64'(cpu_if.cmd_read), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        checks              = 0;
        failures            = 0;
        rst                 = 1'b1;
        cpu_if.cmd          = '0;
        cpu_if.cmd_valid    = 1'b0;
        cpu_if.region       = '0;
        cpu_if.result_ready = 1'b0;
        core_done           = '0;
        core_counter        = '0;
        core_ciphertext     = '0;

        // Reset held three cycles.
        repeat (3) step();
        rst = 1'b0;
        check("rst_cmd_read", 64'(cpu_if.cmd_read), 64'd0);
        check("rst_cmd_err", 64'(cpu_if.cmd_err), 64'd0);
        check("rst_busy", 64'(cpu_if.busy), 64'd0);
        check("rst_result_valid", 64'(cpu_if.result_valid), 64'd0);
        check("rst_core_start", 64'(core_start), 64'd0);
        check("rst_core_restart", 64'(core_restart), 64'd0);
        check("rst_core_region", 64'(core_region), 64'd0);
        check("rst_result_counter", cpu_if.result_counter, 64'd0);

        // SET_REGION core 2, handshake timing checked cycle by cycle.
        cpu_if.cmd       = 32'h0000_0200;
        cpu_if.region    = 32'h00AB_1234;
        cpu_if.cmd_valid = 1'b1;
        check("setreg_read_c", 64'(cpu_if.cmd_read), 64'd0);
        step();
        check("setreg_read_c1", 64'(cpu_if.cmd_read), 64'd1);
        step();
        check("setreg_read_held", 64'(cpu_if.cmd_read), 64'd1);
        cpu_if.cmd_valid = 1'b0;
        check("setreg_read_drop_cycle", 64'(cpu_if.cmd_read), 64'd1);
        step();
        check("setreg_read_fall", 64'(cpu_if.cmd_read), 64'd0);
        check("setreg_region", 64'(core_region), 64'h0000_1234_0000_0000);
        check("setreg_no_err", 64'(cpu_if.cmd_err), 64'd0);

        // START core 1 and deliver one result.
        issue(32'h0000_0101, 32'h0, st_seen, rs_seen);
        check("start1_pulse", 64'(st_seen), 64'h2);
        check("start1_busy", 64'(cpu_if.busy), 64'd1);
        core_done[1]              = 1'b1;
        core_counter[1*CW +: CW]  = 48'h1234_5678_9ABC;
        core_ciphertext[64 +: 64] = 64'hDEAD_BEEF_0123_4567;
        step();
        core_done = '0;
        check("start1_valid_d1", 64'(cpu_if.result_valid), 64'd0);
        step();
        check("start1_valid_d2", 64'(cpu_if.result_valid), 64'd1);
        check("start1_core", 64'(cpu_if.result_core), 64'd1);
        check("start1_counter", cpu_if.result_counter, 64'h0000_1234_5678_9ABC);
        check("start1_ct", cpu_if.result_ciphertext, 64'hDEAD_BEEF_0123_4567);
        step();
        check("start1_hold", 64'(cpu_if.result_valid), 64'd1);
        check("start1_busy_hold", 64'(cpu_if.busy), 64'd1);
        cpu_if.result_ready = 1'b1;
        step();
        cpu_if.result_ready = 1'b0;
        check("start1_consumed", 64'(cpu_if.result_valid), 64'd0);
        check("start1_busy_drop", 64'(cpu_if.busy), 64'd0);

        // Fresh reset so the round-robin pointer starts at NUM_CORES-1 again.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_region", 64'(core_region), 64'd0);
        issue(32'h0000_0000, 32'h0000_BEEF, st_seen, rs_seen);
        check("setreg0_region", 64'(core_region), 64'h0000_0000_0000_BEEF);

        // START_ALL, cores 0 and 3 finish together.
        issue(32'h0000_0002, 32'h0, st_seen, rs_seen);
        check("startall_pulse", 64'(st_seen), 64'hF);
        core_done                       = 4'b1001;
        core_counter[0*CW +: CW]        = 48'h0000_0000_0111;
        core_counter[3*CW +: CW]        = 48'h0000_0000_0333;
        core_ciphertext[0*64 +: 64]     = 64'h0000_0000_0000_00A0;
        core_ciphertext[3*64 +: 64]     = 64'h0000_0000_0000_00A3;
        step();
        core_done = '0;
        step();
        check("tie_core0", 64'(cpu_if.result_core), 64'd0);
        check("tie_cnt0", cpu_if.result_counter, 64'h111);
        step();
        check("tie_hold_valid", 64'(cpu_if.result_valid), 64'd1);
        check("tie_hold_core", 64'(cpu_if.result_core), 64'd0);
        check("tie_hold_ct", cpu_if.result_ciphertext, 64'hA0);
        cpu_if.result_ready = 1'b1;
        step();
        check("b2b_valid", 64'(cpu_if.result_valid), 64'd1);
        check("b2b_core3", 64'(cpu_if.result_core), 64'd3);
        check("b2b_cnt3", cpu_if.result_counter, 64'h333);
        step();
        cpu_if.result_ready = 1'b0;
        check("b2b_empty", 64'(cpu_if.result_valid), 64'd0);

        // Restart cores 0 and 3, tie again: core 0 wins after last grant 3.
        issue(32'h0000_0001, 32'h0, st_seen, rs_seen);
        check("start0_pulse", 64'(st_seen), 64'h1);
        issue(32'h0000_0301, 32'h0, st_seen, rs_seen);
        check("start3_pulse", 64'(st_seen), 64'h8);
        check("start03_no_err", 64'(cpu_if.cmd_err), 64'd0);
        core_done = 4'b1001;
        step();
        core_done = '0;
        step();
        check("tie2_core0", 64'(cpu_if.result_core), 64'd0);
        cpu_if.result_ready = 1'b1;
        step();
        check("tie2_core3", 64'(cpu_if.result_core), 64'd3);
        step();
        cpu_if.result_ready = 1'b0;
        check("tie2_empty", 64'(cpu_if.result_valid), 64'd0);
        check("tie2_busy_running", 64'(cpu_if.busy), 64'd1);

        // START_ALL skips the running cores 1 and 2 without error.
        issue(32'h0000_0002, 32'h0, st_seen, rs_seen);
        check("startall_skip", 64'(st_seen), 64'h9);
        check("startall_no_err", 64'(cpu_if.cmd_err), 64'd0);

        // Core 1 result pending in the slot, core 2 pending behind it.
        core_done = 4'b0010;
        step();
        core_done = 4'b0100;
        step();
        core_done = '0;
        check("pre_restart_valid", 64'(cpu_if.result_valid), 64'd1);
        issue(32'h0000_0003, 32'h0, st_seen, rs_seen);
        check("restart_pulse", 64'(rs_seen), 64'hF);
        check("restart_no_start", 64'(st_seen), 64'h0);
        check("restart_pulse_end", 64'(core_restart), 64'h0);
        check("restart_valid", 64'(cpu_if.result_valid), 64'd0);
        check("restart_busy", 64'(cpu_if.busy), 64'd0);
        check("restart_region_kept", 64'(core_region), 64'h0000_0000_0000_BEEF);
        core_done = 4'b1111;
        step();
        core_done = '0;
        step();
        check("done_ignored_valid", 64'(cpu_if.result_valid), 64'd0);
        check("done_ignored_busy", 64'(cpu_if.busy), 64'd0);

        // Bad index and bad opcode.
        issue(32'h0000_0701, 32'h0, st_seen, rs_seen);
        check("badidx_no_start", 64'(st_seen), 64'h0);
        check("badidx_err", 64'(cpu_if.cmd_err), 64'd1);
        issue(32'h0000_0009, 32'h0, st_seen, rs_seen);
        check("badop_no_start", 64'(st_seen), 64'h0);
        check("badop_err", 64'(cpu_if.cmd_err), 64'd1);
        check("bad_busy", 64'(cpu_if.busy), 64'd0);
        issue(32'h0000_0003, 32'h0, st_seen, rs_seen);
        check("restart_clears_err", 64'(cpu_if.cmd_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
